// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for simple_cpu: loadable program memory, a program counter and
// an IDLE/FETCH/EXEC/HALT sequencer that holds each instruction until done or hold timeout.
module instr_fetch_unit #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   instr_done,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   halted
);

    localparam int DEPTH = 2 ** PC_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [7:0]         HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [PC_BITS-1:0] PC_FIRST  = '0;
    localparam logic [PC_BITS-1:0] PC_LAST   = '1;

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [7:0]             hold_cnt;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [INSTR_WIDTH-1:0] fetch_word;
    logic [PC_BITS-1:0]     pc_inc;
    logic                   idle_like;
    logic                   mem_wr;
    logic                   advance;
    logic                   is_halt_word;

    assign idle_like    = (state == S_IDLE) || (state == S_HALT);
    assign mem_wr       = load_en && idle_like;
    assign advance      = (state == S_EXEC) && (instr_done || (hold_cnt == HOLD_LAST));
    assign is_halt_word = (fetch_word[INSTR_WIDTH-1 -: 2] == 2'b00);
    assign pc_inc       = pc + 1'b1;

    // Program memory has no reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_next = S_FETCH;
            S_FETCH:        state_next = is_halt_word ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (advance) begin
                    state_next = (pc == PC_LAST) ? S_HALT : S_FETCH;
                end
            end
            default:        state_next = S_IDLE;
        endcase
    end

    // fetch_word is latched when entering FETCH, so a write to address 0 in the
    // same cycle as start does not affect the first fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            hold_cnt    <= '0;
            fetch_word  <= '0;
        end else begin
            state       <= state_next;
            instr_valid <= (state_next == S_EXEC);
            busy        <= (state_next == S_FETCH) || (state_next == S_EXEC);
            halted      <= (state_next == S_HALT);
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc         <= PC_FIRST;
                        fetch_word <= mem[PC_FIRST];
                    end
                end
                S_FETCH: begin
                    instruction <= is_halt_word ? '0 : fetch_word;
                    hold_cnt    <= '0;
                end
                S_EXEC: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (advance) begin
                        if (pc == PC_LAST) begin
                            instruction <= '0;
                        end else begin
                            pc         <= pc_inc;
                            fetch_word <= mem[pc_inc];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: randomized program/done stimulus against a behavioural model,
// per-cycle output compare, plus hand-computed checks for the key timing points.
module tb_instr_fetch_unit;

    localparam int W    = 20;
    localparam int PB   = 5;
    localparam int HOLD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          instr_done = 1'b0;
    logic          load_en = 1'b0;
    logic [PB-1:0] load_addr = '0;
    logic [W-1:0]  load_data = '0;
    logic [W-1:0]  instruction;
    logic          instr_valid;
    logic [PB-1:0] pc;
    logic          busy;
    logic          halted;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_unit #(.INSTR_WIDTH(W), .PC_BITS(PB), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .instr_done(instr_done),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: the fetch pipeline described as "fetching", "cycles left in
    // execution" and "halted" rather than an encoded state.
    logic [W-1:0]  m_mem [32];
    logic [W-1:0]  m_w0;
    logic [W-1:0]  m_word;
    logic [W-1:0]  m_instr;
    logic [PB-1:0] m_pc;
    logic          m_fetch;
    logic          m_halted;
    int            m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fetch = 0; m_left = 0; m_halted = 0; m_pc = 0; m_instr = 0;
        end else if (m_fetch) begin
            m_word  = (m_pc == 0) ? m_w0 : m_mem[m_pc];
            m_fetch = 0;
            if (m_word[W-1:W-2] == 2'b00) begin
                m_halted = 1; m_instr = 0;
            end else begin
                m_instr = m_word; m_left = HOLD;
            end
        end else if (m_left > 0) begin
            if (instr_done || m_left == 1) begin
                m_left = 0;
                if (m_pc == 5'd31) begin
                    m_halted = 1; m_instr = 0;
                end else begin
                    m_pc = m_pc + 1; m_fetch = 1;
                end
            end else begin
                m_left--;
            end
        end else begin
            if (start) begin
                m_w0 = m_mem[0]; m_pc = 0; m_fetch = 1; m_halted = 0;
            end
            if (load_en) m_mem[load_addr] = load_data;
        end
    end

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            check("cyc_instruction", instruction, m_instr);
            check("cyc_instr_valid", instr_valid, m_left > 0);
            check("cyc_pc", pc, m_pc);
            check("cyc_busy", busy, m_fetch || m_left > 0);
            check("cyc_halted", halted, m_halted);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [PB-1:0] a, input logic [W-1:0] d);
        load_en = 1; load_addr = a; load_data = d;
        tick(1);
        load_en = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic pulse_done();
        instr_done = 1;
        tick(1);
        instr_done = 0;
    endtask

    task automatic run_to_halt(input bit rand_done, input int budget);
        int i;
        for (i = 0; i < budget && !halted; i++) begin
            instr_done = rand_done ? ($urandom_range(0, 2) == 0) : 1'b0;
            tick(1);
        end
        instr_done = 0;
        check("halt_reached", halted, 1'b1);
    endtask

    task automatic wait_exec_at(input logic [PB-1:0] a, input bit rand_done, input int budget);
        int i;
        for (i = 0; i < budget && !(instr_valid && pc == a); i++) begin
            instr_done = rand_done ? ($urandom_range(0, 2) == 0) : 1'b0;
            tick(1);
        end
        instr_done = 0;
        check("exec_at_reached", instr_valid && pc == a, 1'b1);
    endtask

    logic [W-1:0] fill [32];

    initial begin
        int nv, nb;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;

        // Reset state
        #12;
        check("rst_instruction", instruction, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        @(negedge clk); rst = 0;
        tick(1);

        // ALU, ALU, HALT with done pulses
        load(0, 20'h41234);
        load(1, 20'h45678);
        load(2, 20'h00abc);
        pulse_start();
        check("fetch_busy", busy, 1);
        tick(1);
        check("first_instr", instruction, 20'h41234);
        check("first_valid", instr_valid, 1);
        check("first_pc", pc, 0);
        pulse_done();
        check("adv_pc", pc, 1);
        check("adv_dead_valid", instr_valid, 0);
        check("adv_hold_instr", instruction, 20'h41234);
        tick(1);
        check("second_instr", instruction, 20'h45678);
        pulse_done();
        tick(1);
        check("halt_flag", halted, 1);
        check("halt_instr", instruction, 0);
        check("halt_pc", pc, 2);

        // Hold timeout, no done
        load(0, 20'h8_0001);
        load(1, 20'hc_0002);
        load(2, 20'h4_0003);
        load(3, 20'h8_0004);
        load(4, 20'h0_0005);
        pulse_start();
        nv = 0; nb = 0;
        for (int i = 0; i < 100 && !halted; i++) begin
            nv += int'(instr_valid); nb += int'(busy);
            tick(1);
        end
        check("timeout_halt", halted, 1);
        check("timeout_valid_cycles", nv, 16);
        check("timeout_busy_cycles", nb, 21);
        check("timeout_pc", pc, 4);

        // Done coincident with hold expiry: one increment only
        pulse_start();
        tick(1);
        check("coinc_valid0", instr_valid, 1);
        tick(3);
        pulse_done();
        check("coinc_pc_fetch", pc, 1);
        check("coinc_busy", busy, 1);
        tick(1);
        check("coinc_pc_exec", pc, 1);
        check("coinc_instr", instruction, 20'hc_0002);
        run_to_halt(0, 100);

        // load_en and start during EXEC are ignored
        pulse_start();
        wait_exec_at(1, 0, 50);
        load_en = 1; load_addr = 2; load_data = 20'h7_7777; start = 1;
        tick(1);
        load_en = 0; start = 0;
        check("exec_ignore_pc", pc, 1);
        check("exec_ignore_valid", instr_valid, 1);
        wait_exec_at(2, 0, 50);
        check("exec_ignore_mem", instruction, 20'h4_0003);
        run_to_halt(0, 100);

        // start + load to address 0 in the same HALT cycle: old word fetched first
        load_en = 1; load_addr = 0; load_data = 20'hd_ead0; start = 1;
        tick(1);
        load_en = 0; start = 0;
        tick(1);
        check("same_cycle_old_w0", instruction, 20'h8_0001);
        run_to_halt(1, 200);
        pulse_start();
        tick(1);
        check("same_cycle_new_w0", instruction, 20'hd_ead0);
        run_to_halt(1, 200);

        // Full memory, random done: halt at last address without wrap
        for (int i = 0; i < 32; i++) begin
            fill[i] = {2'($urandom_range(1, 3)), 18'($urandom)};
            load(5'(i), fill[i]);
        end
        pulse_start();
        run_to_halt(1, 2000);
        check("full_pc_last", pc, 31);
        check("full_instr_zero", instruction, 0);

        // Asynchronous reset mid-EXEC, memory preserved
        pulse_start();
        wait_exec_at(3, 1, 200);
        #1 rst = 1;
        #1;
        check("arst_instr", instruction, 0);
        check("arst_pc", pc, 0);
        check("arst_busy", busy, 0);
        check("arst_valid", instr_valid, 0);
        @(negedge clk); rst = 0;
        tick(1);
        pulse_start();
        tick(1);
        check("arst_restart_w0", instruction, fill[0]);
        run_to_halt(1, 2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of `simple_cpu`. It holds a small loadable program memory and a program counter, and presents one 20-bit instruction at a time on the CPU's `instruction` input. Each instruction is held stable until the CPU signals completion, or until a fixed hold count expires for CPU builds without a done strobe. It stops automatically on a HALT-class word or at the end of memory.

## Interface
- `INSTR_WIDTH`, default 20: instruction width, matching the CPU instruction port.
- `PC_BITS`, default 5: program memory has 2^PC_BITS words (32).
- `HOLD_CYCLES`, default 4: maximum cycles spent in EXEC per instruction, legal range 1..255.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin execution from address 0; sampled in IDLE or HALT only.
- `instr_done`  in  1: one-cycle pulse from the CPU, meaning the current instruction has finished.
- `load_en`  in  1: program-memory write strobe.
- `load_addr`  in  PC_BITS: program-memory write address.
- `load_data`  in  INSTR_WIDTH: program-memory write data.
- `instruction`  out  INSTR_WIDTH: registered instruction to the CPU.
- `instr_valid`  out  1: high while in EXEC.
- `pc`  out  PC_BITS: address of the current or next instruction.
- `busy`  out  1: high in FETCH or EXEC.
- `halted`  out  1: high in HALT.

## Operation
- Program memory:
  - Synchronous write `mem[load_addr] <= load_data` when `load_en` is high in IDLE or HALT.
  - `load_en` in FETCH or EXEC is ignored.
  - Memory is not cleared by `rst`.
- HALT word: any word with bits [INSTR_WIDTH-1:INSTR_WIDTH-2] == 2'b00 is HALT-class. ALU = 01, LOAD = 10, STORE = 11.
- States: IDLE, FETCH, EXEC, HALT. All outputs are registered.
- IDLE:
  - `start` → FETCH with `pc <= 0`.
  - Otherwise remain in IDLE.
- FETCH (exactly one cycle):
  - If `mem[pc]` is HALT-class → HALT, with `instruction <= 0`.
  - Otherwise → EXEC, with `instruction <= mem[pc]` and `hold_cnt <= 0`.
  - `instr_done` is ignored.
- EXEC:
  - `hold_cnt` increments every cycle.
  - Advance condition: `instr_done`, or `hold_cnt == HOLD_CYCLES-1`. Both in the same cycle count as a single advance.
  - On advance with `pc == 2^PC_BITS-1` → HALT. `pc` does not wrap and stays at the last address. `instruction <= 0`.
  - On any other advance → FETCH with `pc <= pc+1`.
- HALT:
  - `start` → FETCH with `pc <= 0`.
  - `load_en` is permitted.
- `start` in FETCH or EXEC is ignored. `start` and `load_en` in the same IDLE cycle: both take effect (the write lands, and FETCH sees the new word only if `load_addr != 0`; address 0 fetch reads the pre-write word).
- `instruction` holds its last value through FETCH, so the CPU never sees a glitch between instructions. It reads 0 in IDLE and HALT, which is the CPU's reset-time idle word.
- Counter width: 8 bits. `pc` increment is PC_BITS wide with no carry out.

## Timing
- Reset values:
  - state = IDLE
  - `instruction` = 0, `instr_valid` = 0, `pc` = 0, `busy` = 0, `halted` = 0
  - `hold_cnt` = 0
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous). Memory contents are preserved.
- Start-to-first-valid latency:
  - `start` sampled at edge N.
  - FETCH during cycle N..N+1.
  - `instr_valid` = 1 and `instruction` updated after edge N+1.
- Instruction-to-instruction latency:
  - `instr_done` sampled at edge M.
  - FETCH after edge M.
  - New instruction valid after edge M+1.
  - Net: one dead cycle per instruction.
- Hold timeout with no `instr_done`: EXEC lasts exactly HOLD_CYCLES cycles.
- HOLD_CYCLES = 1: EXEC lasts exactly one cycle per instruction.

## Test plan
- Load three words (ALU, ALU, HALT) at addresses 0..2, pulse `start`:
  - `instruction` = word0 two edges later, with `instr_valid` = 1.
  - A done pulse advances `pc` to 1, and word1 appears two edges later.
  - The next done → `halted` = 1, `instruction` = 0, `pc` = 2.
- Leave `instr_done` tied low with HOLD_CYCLES = 4: each instruction is valid for exactly 4 cycles, followed by one FETCH cycle, at a 5-cycle period.
- Fill all 32 words with non-HALT words, run with done pulses: after the done at `pc` = 31 → HALT with `pc` = 31 (no wrap to 0).
- Assert `rst` mid-EXEC at `pc` = 3: `instruction` = 0, `pc` = 0, IDLE asynchronously. A re-start re-executes word0 with the memory intact.
- Pulse `load_en` and `start` during EXEC:
  - Memory is unchanged (read back after HALT).
  - Execution is not restarted.
- Assert `instr_done` in the same cycle as the hold-counter expiry: exactly one `pc` increment.
